multiword_adder_ctrl: RTL and testbench

Sequencer that performs one OPW = WIDTH*WORDS bit add or subtract by time-multiplexing a single WIDTH-bit ripple `adder` instance over WORDS consecutive cycles, least-significant slice first. A carry register links the slices. The block accepts operands over a valid/ready handshake and presents the result over a second valid/ready handshake. It sits between an operand source (register file or FIFO) and a result consumer wherever a wide add is needed but a full-width carry chain is too slow or too large.

---
 rtl/multiword_adder_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multiword_adder_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_adder_ctrl.sv
// Wide add/subtract built from one WIDTH-bit ripple slice reused over WORDS cycles,
// least-significant slice first, with valid/ready handshakes on operands and result.

module adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = carry[WIDTH];
endmodule

module multiword_adder_ctrl #(
   parameter int WIDTH = 4,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH*WORDS-1:0] a,
   input  logic [WIDTH*WORDS-1:0] b,
   input  logic                   cin,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*WORDS-1:0] s,
   output logic                   cout,
   output logic                   ovf,
   output logic                   busy
);
   localparam int OPW  = WIDTH * WORDS;
   localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [OPW-1:0]   a_q;
   logic [OPW-1:0]   b_q;
   logic             carry_q;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] s_words [WORDS];
   logic             ovf_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;
   logic             busy_reg;

   // Latched operands viewed as word arrays so the slice mux is a plain index.
   logic [WIDTH-1:0] a_words [WORDS];
   logic [WIDTH-1:0] b_words [WORDS];

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_word
         assign a_words[gi]                = a_q[gi*WIDTH +: WIDTH];
         assign b_words[gi]                = b_q[gi*WIDTH +: WIDTH];
         assign s[gi*WIDTH +: WIDTH]       = s_words[gi];
      end
   endgenerate

   logic [WIDTH-1:0] slice_a;
   logic [WIDTH-1:0] slice_b;
   logic [WIDTH-1:0] slice_sum;
   logic             slice_cout;

   assign slice_a = a_words[idx];
   assign slice_b = b_words[idx];

   adder #(.WIDTH(WIDTH)) u_adder (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         carry_q       <= 1'b0;
         idx           <= '0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         for (int i = 0; i < WORDS; i++) begin
            s_words[i] <= '0;
         end
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
                  a_q          <= a;
                  b_q          <= sub ? ~b : b;
                  carry_q      <= sub ? 1'b1 : cin;
                  idx          <= '0;
                  ovf_reg      <= 1'b0;
                  for (int i = 0; i < WORDS; i++) begin
                     s_words[i] <= '0;
                  end
                  state_reg    <= RUN;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
               end
            end
            RUN: begin
               s_words[idx] <= slice_sum;
               carry_q      <= slice_cout;
               if (idx == LAST_IDX) begin
                  // The final slice carries the result sign bit, so overflow resolves now.
                  ovf_reg       <= (a_q[OPW-1] == b_q[OPW-1]) &&
                                   (slice_sum[WIDTH-1] != a_q[OPW-1]);
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign busy      = busy_reg;
   assign cout      = carry_q;
   assign ovf       = ovf_reg;
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Scoreboard bench for multiword_adder_ctrl (16-bit): directed cases plus random
// operands, with expected results from plain integer arithmetic.

module tb_multiword_adder_ctrl;
   localparam int WIDTH = 4;
   localparam int WORDS = 4;
   localparam int OPW   = WIDTH * WORDS;

   typedef struct {
      logic [OPW-1:0] s;
      logic           cout;
      logic           ovf;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [OPW-1:0] op_a = '0;
   logic [OPW-1:0] op_b = '0;
   logic           op_cin = 1'b0;
   logic           op_sub = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [OPW-1:0] s;
   logic           cout;
   logic           ovf;
   logic           busy;

   int n_tests = 0;
   int n_fail  = 0;
   int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the directed test
   exp_t exp_q[$];

   multiword_adder_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (op_a),
      .b         (op_b),
      .cin       (op_cin),
      .sub       (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference: unsigned sum for s/cout, true signed result range for overflow.
   function automatic exp_t model(input logic [OPW-1:0] x, input logic [OPW-1:0] y,
                                  input logic c, input logic sb);
      exp_t e;
      int unsigned ux = x;
      int unsigned uy = y;
      int sx = $signed(x);
      int sy = $signed(y);
      int sres;
      int unsigned full;
      if (sb) begin
         e.s    = OPW'(ux - uy);
         e.cout = (ux >= uy);
         sres   = sx - sy;
      end else begin
         full   = ux + uy + (c ? 1 : 0);
         e.s    = OPW'(full);
         e.cout = (full >= (1 << OPW));
         sres   = sx + sy + (c ? 1 : 0);
      end
      e.ovf = (sres > ((1 << (OPW - 1)) - 1)) || (sres < -(1 << (OPW - 1)));
      return e;
   endfunction

   // Presents one operation, waits for acceptance, queues its expected result.
   task automatic issue(input logic [OPW-1:0] x, input logic [OPW-1:0] y,
                        input logic c, input logic sb);
      int t;
      @(negedge clk);
      op_a = x; op_b = y; op_cin = c; op_sub = sb; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL accept_timeout: in_ready got 0, required 1");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back(model(x, y, c, sb));
      #1;
      in_valid = 1'b0;
      op_a = OPW'($urandom);
      op_b = OPW'($urandom);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_queue", exp_q.size(), 0);
   endtask

   always @(posedge clk) begin
      #2;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
   end

   // Monitor: every completed result handshake is checked against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL unexpected_result: got s=%h, required no result", s);
            end else begin
               e = exp_q.pop_front();
               $display("[TB] result s=%h cout=%b ovf=%b (model s=%h cout=%b ovf=%b)",
                        s, cout, ovf, e.s, e.cout, e.ovf);
               chk("result_s", 32'(s), 32'(e.s));
               chk("result_cout", 32'(cout), 32'(e.cout));
               chk("result_ovf", 32'(ovf), 32'(e.ovf));
            end
         end
      end
   end

   initial begin
      int lat;
      logic [OPW-1:0] held_s;
      logic           held_cout;
      logic [OPW-1:0] ra, rb;
      int pick;

      repeat (3) @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 1);
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_s", 32'(s), 0);
      chk("reset_cout", 32'(cout), 0);
      chk("reset_ovf", 32'(ovf), 0);
      rst = 1'b0;

      // Basic add with latency measurement.
      issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk("run_busy", 32'(busy), 1);
            chk("run_in_ready", 32'(in_ready), 0);
         end
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      chk("latency", lat, WORDS + 1);
      drain();

      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      issue(16'h8000, 16'h8000, 1'b0, 1'b0);
      issue(16'h0007, 16'h0005, 1'b1, 1'b1);
      issue(16'h0005, 16'h0007, 1'b1, 1'b1);
      drain();

      // Backpressure: result held while the consumer stalls and in_valid toggles.
      ready_mode = 2;
      @(posedge clk); #2 out_ready = 1'b0;
      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      lat = 0;
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      held_s = s;
      held_cout = cout;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_s_stable", 32'(s), 32'(held_s));
         chk("bp_cout_stable", 32'(cout), 32'(held_cout));
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_valid_held", 32'(out_valid), 1);
         in_valid = (k % 2 == 0);
         op_a = OPW'($urandom);
      end
      @(posedge clk); #2;
      out_ready = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_in_ready", 32'(in_ready), 1);
      chk("bp_idle_out_valid", 32'(out_valid), 0);
      chk("bp_no_extra_op", exp_q.size(), 0);
      ready_mode = 0;

      // Reset during the second RUN cycle discards the operation.
      issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_s", 32'(s), 0);
      rst = 1'b0;
      issue(16'h1234, 16'h1111, 1'b0, 1'b0);
      drain();

      // Random operations under random backpressure, biased toward edge values.
      ready_mode = 1;
      for (int n = 0; n < 40; n++) begin
         pick = $urandom_range(0, 5);
         case (pick)
            0: ra = 16'hFFFF;
            1: ra = 16'h7FFF;
            2: ra = 16'h8000;
            default: ra = OPW'($urandom);
         endcase
         rb = ($urandom_range(0, 3) == 0) ? ra : OPW'($urandom);
         issue(ra, rb, 1'($urandom), 1'($urandom));
      end
      drain();
      ready_mode = 0;

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
